// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the writeback sources, the arbiter and the
// register file write port.
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0][4:0]      req_addr;
   logic [NUM_REQ-1:0][XLEN-1:0] req_dat;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         write_en;
   logic [4:0]                   write_addr;
   logic [XLEN-1:0]              write_dat;

   // Writeback sources drive requests and observe grants and the write port.
   modport master (
      output req_valid, req_addr, req_dat,
      input  req_ready, write_en, write_addr, write_dat
   );

   // The arbiter consumes requests and drives grants and the write port.
   modport slave (
      input  req_valid, req_addr, req_dat,
      output req_ready, write_en, write_addr, write_dat
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port, with a
// per-register pending-write scoreboard used by decode for hazard stalls.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_wb_arbiter_if.slave  bus,
   input  logic                 issue_en,
   input  logic [4:0]           issue_addr,
   output logic                 issue_stall,
   input  logic                 flush,
   output logic [31:0]          busy_vec,
   output logic                 sb_underflow
);

   localparam int RR_W = (NUM_REQ > 2) ? 2 : 1;

   logic [RR_W-1:0]    rr;
   logic [RR_W-1:0]    gnt;
   logic               xfer;
   logic [NUM_REQ-1:0] ready;
   logic [4:0]         gnt_addr;
   logic [XLEN-1:0]    gnt_dat;
   logic               inc;
   logic               dec;
   logic [31:0]        inc_vec;
   logic [31:0]        dec_vec;
   logic [1:0]         cnt [32];

   // Pick the first valid requester at or after rr, wrapping; no grant in reset or flush.
   always_comb begin
      int idx;
      // NOTE: combinational blocks use blocking assignments and default every output first, so no latch is inferred.
      xfer  = 1'b0;
      gnt   = '0;
      ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!xfer && bus.req_valid[idx]) begin
            xfer = 1'b1;
            gnt  = RR_W'(idx);
         end
      end
      if (!rst_n || flush) xfer = 1'b0;
      if (xfer) ready[gnt] = 1'b1;
   end

   assign bus.req_ready = ready;
   assign gnt_addr      = bus.req_addr[gnt];
   assign gnt_dat       = bus.req_dat[gnt];

   // Advance the pointer past the winner; flush returns it to requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (!rst_n)
         rr <= '0;
      else if (flush)
         rr <= '0;
      else if (xfer)
         rr <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + RR_W'(1);
   end

   // Registered write port; a transfer to x0 is consumed without a write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.write_en   <= 1'b0;
         bus.write_addr <= '0;
         bus.write_dat  <= '0;
      end else if (xfer) begin
         bus.write_en   <= (gnt_addr != 5'd0);
         bus.write_addr <= gnt_addr;
         bus.write_dat  <= gnt_dat;
      end else begin
         bus.write_en   <= 1'b0;
      end
   end

   // Stall decode when the destination's pending count is already saturated.
   assign issue_stall = rst_n & issue_en & (issue_addr != 5'd0) & (cnt[issue_addr] == 2'd3);

   assign inc = issue_en & ~flush & (issue_addr != 5'd0) & ~issue_stall;
   assign dec = xfer & (gnt_addr != 5'd0);

   // One-hot increment/decrement targets for the scoreboard.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (inc) inc_vec[issue_addr] = 1'b1;
      if (dec) dec_vec[gnt_addr]   = 1'b1;
   end

   // Pending-write counters; x0 is never touched after reset and stays 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the counter array is small and must start clean, so every entry is reset explicitly.
         for (int r = 0; r < 32; r++) cnt[r] <= 2'd0;
         sb_underflow <= 1'b0;
      end else if (flush) begin
         for (int r = 0; r < 32; r++) cnt[r] <= 2'd0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (inc_vec[r] && !dec_vec[r])
               cnt[r] <= cnt[r] + 2'd1;
            else if (!inc_vec[r] && dec_vec[r] && cnt[r] != 2'd0)
               cnt[r] <= cnt[r] - 2'd1;
         end
         if (dec && cnt[gnt_addr] == 2'd0) sb_underflow <= 1'b1;
      end
   end

   // A register is busy while any write to it is outstanding.
   always_comb begin
      for (int r = 0; r < 32; r++) busy_vec[r] = (cnt[r] != 2'd0);
      busy_vec[0] = 1'b0;
   end

endmodule
